// File: rtl/phoenix_ni_tx_pkg.sv
// Shared constants for the Phoenix NoC local-port injector: flit width,
// FSM state encodings and flit-position indices within a packet.
package phoenix_ni_tx_pkg;

  localparam int TAM_FLIT_DEF = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HEADER  = 2'd1;
  localparam logic [1:0] ST_SIZE    = 2'd2;
  localparam logic [1:0] ST_PAYLOAD = 2'd3;

  // Position of the framing flits inside a packet on the wire.
  localparam int FLIT_HEADER = 0;
  localparam int FLIT_SIZE   = 1;

endpackage

// File: rtl/phoenix_ni_fifo.sv
// First-word-fall-through payload FIFO with registered full/empty flags;
// a write while full is dropped even if a read happens in the same cycle.
module phoenix_ni_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign o_empty   = (wr_ptr == rd_ptr);
  assign o_full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_ok     = i_wr_en && !o_full;
  assign rd_ok     = i_rd_en && !o_empty;
  assign o_rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: storage has no reset; emptiness is defined by the pointers alone,
  // so clearing them is enough and keeps the array as plain RAM.
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/phoenix_ni_tx.sv
// Phoenix NoC local-port injector: serialises header, size and payload flits
// under credit flow control. Statistics counters exist only with PHOENIX_NI_TX_STATS_EN.
module phoenix_ni_tx
  import phoenix_ni_tx_pkg::*;
#(
  parameter int TAM_FLIT   = TAM_FLIT_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req,
  input  logic [TAM_FLIT-1:0] i_target,
  input  logic [TAM_FLIT-1:0] i_size,
  output logic                o_ready,
  input  logic                i_pl_valid,
  input  logic [TAM_FLIT-1:0] i_pl_data,
  output logic                o_pl_ready,
  input  logic                i_credit,
  output logic                o_tx,
  output logic [TAM_FLIT-1:0] o_data,
  output logic                o_clk_tx,
  output logic [31:0]         o_pkt_cnt,
  output logic [31:0]         o_stall_cnt
);

  logic [1:0]          state;
  logic [TAM_FLIT-1:0] size_q;
  logic [TAM_FLIT-1:0] remaining;
  logic [TAM_FLIT-1:0] fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                xfer;
  logic                last_flit;
  logic                load_head;

  assign o_clk_tx   = i_clk;
  assign o_pl_ready = !fifo_full;

  phoenix_ni_fifo #(
    .WIDTH (TAM_FLIT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (i_pl_valid),
    .i_wr_data (i_pl_data),
    .i_rd_en   (load_head),
    .o_rd_data (fifo_head),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty)
  );

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    xfer      = o_tx && i_credit;
    last_flit = 1'b0;
    load_head = 1'b0;
    case (state)
      ST_SIZE: begin
        last_flit = (size_q == '0);
        load_head = xfer && !last_flit && !fifo_empty;
      end
      ST_PAYLOAD: begin
        last_flit = (remaining == TAM_FLIT'(1));
        // Refill after a non-final transfer, or end a bubble once data arrives.
        load_head = !fifo_empty && (xfer ? !last_flit : !o_tx);
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= ST_IDLE;
      o_tx      <= 1'b0;
      o_data    <= '0;
      o_ready   <= 1'b1;
      size_q    <= '0;
      remaining <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_req) begin
            o_data  <= i_target;
            size_q  <= i_size;
            o_tx    <= 1'b1;
            o_ready <= 1'b0;
            state   <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (xfer) begin
            o_data <= size_q;
            state  <= ST_SIZE;
          end
        end
        ST_SIZE: begin
          if (xfer) begin
            if (last_flit) begin
              o_tx    <= 1'b0;
              o_ready <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              remaining <= size_q;
              o_tx      <= load_head;
              state     <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (xfer && last_flit) begin
            o_tx    <= 1'b0;
            o_ready <= 1'b1;
            state   <= ST_IDLE;
          end else if (xfer || !o_tx) begin
            o_tx <= load_head;
            if (xfer) remaining <= remaining - TAM_FLIT'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (load_head) o_data <= fifo_head;
    end
  end

`ifdef PHOENIX_NI_TX_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (xfer && last_flit) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (o_tx && !i_credit) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_pkt_cnt   = pkt_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`else
  assign o_pkt_cnt   = '0;
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_phoenix_ni_tx.sv
// Self-checking bench for phoenix_ni_tx: a packet-level model (header, size,
// then size flits drained in order from a payload queue) checked by a monitor.
module tb_phoenix_ni_tx;

  localparam int W = 16;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b0;
  logic         i_req = 1'b0;
  logic [W-1:0] i_target = '0;
  logic [W-1:0] i_size = '0;
  logic         i_pl_valid = 1'b0;
  logic [W-1:0] i_pl_data = '0;
  logic         i_credit = 1'b1;
  logic         o_ready, o_pl_ready, o_tx, o_clk_tx;
  logic [W-1:0] o_data;
  logic [31:0]  o_pkt_cnt, o_stall_cnt;

  phoenix_ni_tx #(.TAM_FLIT(W), .FIFO_DEPTH(8)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (i_req),
    .i_target    (i_target),
    .i_size      (i_size),
    .o_ready     (o_ready),
    .i_pl_valid  (i_pl_valid),
    .i_pl_data   (i_pl_data),
    .o_pl_ready  (o_pl_ready),
    .i_credit    (i_credit),
    .o_tx        (o_tx),
    .o_data      (o_data),
    .o_clk_tx    (o_clk_tx),
    .o_pkt_cnt   (o_pkt_cnt),
    .o_stall_cnt (o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [W-1:0] target;
    logic [W-1:0] size;
  } pkt_t;

  pkt_t         pkt_q[$];
  logic [W-1:0] pl_q[$];
  pkt_t         cur;
  int           mon_pos = 0;
  int           mon_rem = 0;
  int           pkt_exp = 0;
  int           stall_exp = 0;
  int           n_checks = 0;
  int           n_pass = 0;
  bit           rnd_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: condition not reached (t=%0t)", name, $time);
  endtask

  // Monitor: walks the expected framing of every packet on each transfer.
  always @(negedge i_clk) begin
    if (i_rst) begin
      if (o_tx && !i_credit) stall_exp++;
      if (o_tx && i_credit) begin
        if (mon_pos == 0) begin
          if (pkt_q.size() == 0) fail_now("unexpected_flit");
          else begin
            cur = pkt_q.pop_front();
            check("header", 32'(o_data), 32'(cur.target));
            mon_pos = 1;
          end
        end else if (mon_pos == 1) begin
          check("size", 32'(o_data), 32'(cur.size));
          if (cur.size == '0) begin
            pkt_exp++;
            mon_pos = 0;
          end else begin
            mon_rem = int'(cur.size);
            mon_pos = 2;
          end
        end else begin
          if (pl_q.size() == 0) fail_now("payload_underflow");
          else check("payload", 32'(o_data), 32'(pl_q.pop_front()));
          mon_rem--;
          if (mon_rem == 0) begin
            pkt_exp++;
            mon_pos = 0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!o_ready && n < 500) begin
      step();
      n++;
    end
    if (!o_ready) fail_now("ready_timeout");
  endtask

  task automatic send_req(input logic [W-1:0] t, input logic [W-1:0] s);
    pkt_t p;
    wait_ready();
    p.target = t;
    p.size   = s;
    pkt_q.push_back(p);
    i_req    = 1'b1;
    i_target = t;
    i_size   = s;
    step();
    i_req = 1'b0;
  endtask

  task automatic write_pl(input logic [W-1:0] d);
    int n = 0;
    i_pl_data = d;
    while (!o_pl_ready && n < 2000) begin
      step();
      n++;
    end
    if (!o_pl_ready) fail_now("pl_ready_timeout");
    else begin
      pl_q.push_back(d);
      i_pl_valid = 1'b1;
      step();
      i_pl_valid = 1'b0;
    end
  endtask

  // mode 0: plain; 1: 3-cycle credit stall on 00A2; 2: late writes of 00A2/00A3.
  task automatic run_pkt(input int mode, output int cycles, output int gaps, output int held);
    int stall_left = 3;
    cycles = 0;
    gaps   = 0;
    held   = 0;
    while (!o_ready && cycles < 100) begin
      if (!o_tx) gaps++;
      if (o_tx && o_data == 16'h00A2) held++;
      i_credit   = 1'b1;
      i_pl_valid = 1'b0;
      if (mode == 1 && o_tx && o_data == 16'h00A2 && stall_left > 0) begin
        i_credit = 1'b0;
        stall_left--;
      end
      if (mode == 2 && (cycles == 6 || cycles == 8)) begin
        i_pl_data  = (cycles == 6) ? 16'h00A2 : 16'h00A3;
        i_pl_valid = 1'b1;
        pl_q.push_back(i_pl_data);
      end
      step();
      cycles++;
    end
    i_credit   = 1'b1;
    i_pl_valid = 1'b0;
    if (!o_ready) fail_now("packet_timeout");
  endtask

  task automatic check_stats(input string tag);
`ifdef PHOENIX_NI_TX_STATS_EN
    check({tag, "_pkt_cnt"}, o_pkt_cnt, 32'(pkt_exp));
    check({tag, "_stall_cnt"}, o_stall_cnt, 32'(stall_exp));
`else
    check({tag, "_pkt_cnt"}, o_pkt_cnt, 32'd0);
    check({tag, "_stall_cnt"}, o_stall_cnt, 32'd0);
`endif
  endtask

  initial begin
    int cyc, gaps, held, n;
    int sizes[20];
    int total;
    logic [31:0] stall_before;

    repeat (3) @(posedge i_clk);
    #1;
    check("rst_tx", 32'(o_tx), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_pl_ready", 32'(o_pl_ready), 32'd1);
    check_stats("rst");
    i_rst = 1'b1;
    step();

    // Pre-filled FIFO, credit always high: N+2 back-to-back cycles.
    write_pl(16'h00A1); write_pl(16'h00A2); write_pl(16'h00A3);
    send_req(16'h0011, 16'h0003);
    run_pkt(0, cyc, gaps, held);
    check("basic_cycles", 32'(cyc), 32'd5);
    check("basic_gaps", 32'(gaps), 32'd0);
    check("basic_tx_low", 32'(o_tx), 32'd0);

    // Credit withdrawn for 3 cycles while 00A2 is presented.
    stall_before = o_stall_cnt;
    write_pl(16'h00A1); write_pl(16'h00A2); write_pl(16'h00A3);
    send_req(16'h0011, 16'h0003);
    run_pkt(1, cyc, gaps, held);
    check("stall_cycles", 32'(cyc), 32'd8);
    check("stall_held", 32'(held), 32'd4);
`ifdef PHOENIX_NI_TX_STATS_EN
    check("stall_delta", o_stall_cnt - stall_before, 32'd3);
`endif
    check_stats("stall");

    // FIFO runs dry after 00A1; the rest arrives late.
    write_pl(16'h00A1);
    send_req(16'h0011, 16'h0003);
    run_pkt(2, cyc, gaps, held);
    check("bubble_seen", 32'(gaps > 0), 32'd1);
    check("bubble_done", 32'(o_ready), 32'd1);

    // Zero-size packet leaves the queued payload for the next packet.
    write_pl(16'h00E1);
    send_req(16'h0022, 16'h0000);
    run_pkt(0, cyc, gaps, held);
    check("size0_cycles", 32'(cyc), 32'd2);
    send_req(16'h0044, 16'h0001);
    run_pkt(0, cyc, gaps, held);
    check("size1_cycles", 32'(cyc), 32'd3);

    // Nine writes into an idle depth-8 FIFO: the ninth is dropped.
    for (int i = 0; i < 9; i++) begin
      if (i == 8) check("full_pl_ready", 32'(o_pl_ready), 32'd0);
      i_pl_valid = 1'b1;
      i_pl_data  = 16'h00B0 + 16'(i);
      if (i < 8) pl_q.push_back(i_pl_data);
      step();
    end
    i_pl_valid = 1'b0;
    check("full_after", 32'(o_pl_ready), 32'd0);
    send_req(16'h0055, 16'h0008);
    run_pkt(0, cyc, gaps, held);
    check("full_drain_cycles", 32'(cyc), 32'd10);
    check("drained_pl_ready", 32'(o_pl_ready), 32'd1);
    write_pl(16'h00C0);
    send_req(16'h0066, 16'h0001);
    run_pkt(0, cyc, gaps, held);
    check_stats("directed");

    // Randomised traffic with random credit and payload timing.
    total = 0;
    foreach (sizes[k]) begin
      sizes[k] = int'($urandom_range(0, 5));
      total += sizes[k];
    end
    fork
      begin
        fork
          begin
            foreach (sizes[k]) send_req(16'($urandom), 16'(sizes[k]));
          end
          begin
            for (int k = 0; k < total; k++) begin
              repeat ($urandom_range(0, 2)) step();
              write_pl(16'($urandom));
            end
          end
        join
        n = 0;
        while ((pkt_q.size() != 0 || pl_q.size() != 0 || mon_pos != 0 || !o_ready) && n < 3000) begin
          step();
          n++;
        end
        if (n >= 3000) fail_now("random_drain_timeout");
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          i_credit = ($urandom_range(0, 3) != 0);
          step();
        end
      end
    join
    i_credit = 1'b1;
    step();
    check_stats("random");

    // Asynchronous reset in the middle of a payload.
    write_pl(16'h00F1); write_pl(16'h00F2);
    send_req(16'h0077, 16'h0004);
    n = 0;
    while (!(o_tx && o_data == 16'h00F1) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) fail_now("reach_payload");
    #2 i_rst = 1'b0;
    #1;
    check("async_rst_tx", 32'(o_tx), 32'd0);
    check("async_rst_data", 32'(o_data), 32'd0);
    check("async_rst_ready", 32'(o_ready), 32'd1);
    pkt_q.delete();
    pl_q.delete();
    mon_pos   = 0;
    mon_rem   = 0;
    pkt_exp   = 0;
    stall_exp = 0;
    #3 i_rst = 1'b1;
    step();
    check("post_rst_ready", 32'(o_ready), 32'd1);
    check("post_rst_pl_ready", 32'(o_pl_ready), 32'd1);
    check_stats("post_rst");
    write_pl(16'h00D0);
    send_req(16'h0088, 16'h0001);
    run_pkt(0, cyc, gaps, held);
    check("post_rst_cycles", 32'(cyc), 32'd3);
    check_stats("final");
    check("final_pkt_q", 32'(pkt_q.size()), 32'd0);
    check("final_pl_q", 32'(pl_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/phoenix_ni_tx.md
# phoenix_ni_tx

Local-port packet injector for the Phoenix NoC. It takes a packet request (target address, payload size) and a stream of payload flits from the attached core. It serialises header, size and payload flits onto the router's local input, using credit-based flow control. It drives the same i_rx/i_data/i_clk_rx/o_credit signals the router's local buffer consumes, seen from the sending side.

## Interface
Parameters:
- TAM_FLIT, `TAM_FLIT: flit width in bits.
- FIFO_DEPTH, 8: payload FIFO entries; power of two, ≥2.

Ports:
- i_clk  in  1  single clock for the whole block.
- i_rst  in  1  reset. Asynchronous, active-low.
- i_req  in  1  packet request; accepted when o_ready=1.
- i_target  in  TAM_FLIT  header flit value (target XY address); captured on accept.
- i_size  in  TAM_FLIT  number of payload flits; captured on accept.
- o_ready  out  1  block is idle and accepts i_req.
- i_pl_valid  in  1  payload flit valid.
- i_pl_data  in  TAM_FLIT  payload flit.
- o_pl_ready  out  1  payload FIFO not full.
- i_credit  in  1  router local buffer has space (router o_credit).
- o_tx  out  1  flit valid toward router (router i_rx).
- o_data  out  TAM_FLIT  flit toward router (router i_data).
- o_clk_tx  out  1  equal to i_clk.
- o_pkt_cnt  out  32  packets sent (see Configuration).
- o_stall_cnt  out  32  credit-stall cycles (see Configuration).

## Operation
- States: IDLE, HEADER, SIZE, PAYLOAD.
- IDLE: o_ready=1, o_tx=0. Accepting i_req latches i_target and i_size, loads o_data with i_target, sets o_tx=1, and moves to HEADER.
- Flit transfer: a flit transfers on a rising edge where o_tx=1 and i_credit=1.
- While o_tx=1 and i_credit=0, o_tx and o_data hold unchanged.
- HEADER, on transfer: o_data becomes the size flit, then move to SIZE.
- SIZE, on transfer:
  - size=0: o_tx=0, return to IDLE (2-flit packet).
  - size>0: remaining counter = size; load the FIFO head if non-empty (o_tx=1), otherwise o_tx=0. Move to PAYLOAD.
- PAYLOAD:
  - Each transfer decrements the counter.
  - When the counter reaches 0, o_tx=0 and go to IDLE.
  - Otherwise present the next FIFO head, or bubble (o_tx=0) if the FIFO is empty.
  - During a bubble, o_tx rises the cycle after the FIFO becomes non-empty.
- Counter width is TAM_FLIT. Size 0xFFFF (16-bit) is legal and sends 65535 payload flits.
- Payload FIFO is first-word-fall-through.
  - Write when i_pl_valid && o_pl_ready.
  - o_pl_ready = !full, computed from registered state. A write while full is dropped even if a read occurs in the same cycle.
  - No bypass when empty.
  - Excess payload beyond size remains queued for the next packet.
- i_req outside IDLE is ignored.
- Reset at any time: state=IDLE, o_tx=0, o_data=0, counters 0, FIFO emptied, o_ready=1, o_pl_ready=1. A packet in flight is truncated; this is acceptable only for system reset.

## Timing
- Reset values: o_tx=0, o_data=0, o_ready=1, o_pl_ready=1, o_pkt_cnt=0, o_stall_cnt=0.
- All outputs except o_clk_tx are registered.
- Header appears on o_tx/o_data 1 cycle after the i_req accept edge.
- With credit always high and the FIFO pre-filled, a size-N packet occupies N+2 consecutive cycles.
- o_ready returns 1 the cycle after the last transfer, so there is one idle cycle between packets.
- A FIFO write becomes visible to the output no earlier than 1 cycle later.

## Configuration
- PHOENIX_NI_TX_STATS_EN defined:
  - o_pkt_cnt increments on the transfer of the final flit of each packet.
  - o_stall_cnt increments every cycle with o_tx=1 && i_credit=0.
  - Both counters wrap at 2^32.
- Not defined: both ports are tied to 0 and no counter registers exist.

## Structure
- State encodings and flit-position constants (header=0, size=1) go in defines.vh alongside `TAM_FLIT and the port indices.
- One sub-module: phoenix_ni_fifo, a parameterised FWFT FIFO with full and empty flags.

## Test plan
- Reset: hold i_rst=0 → o_tx=0, o_data=0, o_ready=1, o_pl_ready=1.
- FIFO pre-filled with 00A1, 00A2, 00A3, credit=1, req target=0011, size=0003 → o_data sequence 0011, 0003, 00A1, 00A2, 00A3 on 5 consecutive cycles starting 1 cycle after accept; o_ready=1 on the following cycle.
- Same packet, i_credit=0 for 3 cycles while 00A2 is presented → o_tx=1 and o_data=00A2 held 4 cycles; 00A3 follows; total 8 cycles.
- FIFO empty after 00A1, 00A2 written 4 cycles later → o_tx=0 bubble; 00A2 then 00A3 sent once written; packet completes.
- size=0000 → exactly 2 flits; FIFO contents untouched. Writing 9 flits at depth 8 → 9th dropped, o_pl_ready=0 while full.
- i_rst pulsed low mid-PAYLOAD → o_tx=0 immediately (asynchronous); after release o_ready=1 and FIFO empty. With the stats macro defined, a 3-cycle stall gives o_stall_cnt=3 and o_pkt_cnt increments by 1 per completed packet.
